cv32e41s_irq_sequencer: RTL and testbench

- Sits between the interrupt sources and the core controller.
- Captures pending interrupts, either level-sensitive or latched on a rising edge per line, then qualifies them with MIE and a global enable.
- Selects one interrupt using the core's fixed priority order and presents it to the controller with a req/ack handshake.
- After each acknowledge it enforces a programmable quiet gap before the next request.

---
 rtl/cv32e41s_irq_sequencer.sv | 115 +++++++++++
 tb/tb_cv32e41s_irq_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cv32e41s_irq_sequencer.sv
// cv32e41s_irq_sequencer: captures level/edge interrupts, picks one by core priority, req/ack handshake with post-ack gap; CV32E41S_IRQ_SEQ_STATS_EN adds ack/withdraw counters
module cv32e41s_irq_sequencer #(
  parameter logic [31:0] EDGE_MASK  = 32'h0000_0000,
  parameter logic [31:0] IRQ_MASK   = 32'hFFFF_0888,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] irq_i,
  input  logic [31:0] mie_i,
  input  logic        global_en_i,
  output logic        irq_req_o,
  output logic [4:0]  irq_id_o,
  input  logic        irq_ack_i,
  output logic [31:0] pending_o,
  output logic        busy_o
`ifdef CV32E41S_IRQ_SEQ_STATS_EN
  ,
  output logic [15:0] ack_cnt_o,
  output logic [15:0] wdraw_cnt_o
`endif
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
  logic [31:0] irq_q, irq_d, prev_q, prev_d, edge_pend_q, edge_pend_d, pending, qual;
  logic [1:0]  state_q, state_d;
  logic [4:0]  id_q, id_d, sel_id;
  logic [3:0]  cnt_q, cnt_d;
  logic        ack_take, wdraw;
  // input sampling, edge latching and qualification
  always_comb begin
    irq_d       = irq_i & IRQ_MASK;
    prev_d      = irq_q;
    pending     = (irq_q & ~EDGE_MASK) | edge_pend_q;
    qual        = pending & mie_i;
    ack_take    = (state_q == REQ) && irq_ack_i;
    wdraw       = (state_q == REQ) && !irq_ack_i && (!qual[id_q] || !global_en_i);
    edge_pend_d = (edge_pend_q & ~(ack_take ? (32'd1 << id_q) : 32'd0)) | (irq_q & ~prev_q & EDGE_MASK);
  end
  // fixed priority: later assignments win, so lowest priority goes first
  always_comb begin
    sel_id = qual[5] ? 5'd5 : 5'd0;
    sel_id = qual[1] ? 5'd1 : sel_id;
    sel_id = qual[9] ? 5'd9 : sel_id;
    sel_id = qual[7] ? 5'd7 : sel_id;
    sel_id = qual[3] ? 5'd3 : sel_id;
    sel_id = qual[11] ? 5'd11 : sel_id;
    for (int i = 16; i < 32; i++) sel_id = qual[i] ? 5'(i) : sel_id;
  end
  // request sequencing; ack beats withdraw, no preemption while requesting
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = ((|qual) && global_en_i) ? REQ : IDLE;
        id_d    = ((|qual) && global_en_i) ? sel_id : id_q;
      end
      REQ: begin
        state_d = ack_take ? ((GAP_CYCLES == 0) ? IDLE : GAP) : (wdraw ? IDLE : REQ);
        cnt_d   = ack_take ? GAP_LOAD : cnt_q;
      end
      GAP: begin
        state_d = (cnt_q == 4'd0) ? IDLE : GAP;
        cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q       <= '0;
      prev_q      <= '0;
      edge_pend_q <= '0;
      state_q     <= IDLE;
      id_q        <= '0;
      cnt_q       <= '0;
    end else begin
      irq_q       <= irq_d;
      prev_q      <= prev_d;
      edge_pend_q <= edge_pend_d;
      state_q     <= state_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
    end
  end
  assign irq_req_o = state_q == REQ;
  assign irq_id_o  = id_q;
  assign pending_o = pending;
  assign busy_o    = (state_q == REQ) || (state_q == GAP);
`ifdef CV32E41S_IRQ_SEQ_STATS_EN
  logic [15:0] ack_cnt_q, ack_cnt_d, wdraw_cnt_q, wdraw_cnt_d;
  // saturating event counters
  always_comb begin
    ack_cnt_d   = (ack_take && ack_cnt_q != 16'hFFFF) ? ack_cnt_q + 16'd1 : ack_cnt_q;
    wdraw_cnt_d = (wdraw && wdraw_cnt_q != 16'hFFFF) ? wdraw_cnt_q + 16'd1 : wdraw_cnt_q;
  end
  // counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_cnt_q   <= '0;
      wdraw_cnt_q <= '0;
    end else begin
      ack_cnt_q   <= ack_cnt_d;
      wdraw_cnt_q <= wdraw_cnt_d;
    end
  end
  assign ack_cnt_o   = ack_cnt_q;
  assign wdraw_cnt_o = wdraw_cnt_q;
`endif
endmodule

// File: tb/tb_cv32e41s_irq_sequencer.sv
// tb_cv32e41s_irq_sequencer: directed stimulus checked every cycle against a behavioural model
module tb_cv32e41s_irq_sequencer;
  localparam logic [31:0] EDGE = 32'h0012_0000;
  localparam logic [31:0] MASK = 32'hFFFF_0AAA;
  localparam int unsigned GAP = 2;
  logic clk = 0, rst, gen, ack;
  logic [31:0] irq, mie, pending_o;
  logic irq_req_o, busy_o;
  logic [4:0] irq_id_o;
  int errors = 0, checks = 0, n;
  logic [31:0] m_in1, m_in2, m_edge, mp, mq, mclr;
  logic m_req;
  logic [4:0] m_id;
  int m_quiet, ms;
  logic [15:0] m_acks, m_wd;
`ifdef CV32E41S_IRQ_SEQ_STATS_EN
  logic [15:0] ack_cnt_o, wdraw_cnt_o;
`endif
  cv32e41s_irq_sequencer #(.EDGE_MASK(EDGE), .IRQ_MASK(MASK), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .irq_i(irq), .mie_i(mie), .global_en_i(gen),
    .irq_req_o(irq_req_o), .irq_id_o(irq_id_o), .irq_ack_i(ack),
    .pending_o(pending_o), .busy_o(busy_o)
`ifdef CV32E41S_IRQ_SEQ_STATS_EN
    , .ack_cnt_o(ack_cnt_o), .wdraw_cnt_o(wdraw_cnt_o)
`endif
  );
  always #5 clk = ~clk;
  function automatic int pick(input logic [31:0] q);
    for (int k = 31; k >= 16; k--) if (q[k]) return k;
    if (q[11]) return 11;
    if (q[3]) return 3;
    if (q[7]) return 7;
    if (q[9]) return 9;
    if (q[1]) return 1;
    if (q[5]) return 5;
    return -1;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      m_in1 = 0; m_in2 = 0; m_edge = 0; m_req = 0; m_id = 0; m_quiet = 0; m_acks = 0; m_wd = 0;
    end else begin
      mp = (m_in1 & ~EDGE) | m_edge;
      mq = mp & mie;
      mclr = 0;
      if (m_req && ack) begin
        mclr[m_id] = 1'b1; m_req = 0; m_quiet = GAP;
        if (m_acks != 16'hFFFF) m_acks++;
      end else if (m_req && (!mq[m_id] || !gen)) begin
        m_req = 0;
        if (m_wd != 16'hFFFF) m_wd++;
      end else if (!m_req && m_quiet > 0) m_quiet--;
      else if (!m_req && gen) begin
        ms = pick(mq);
        if (ms >= 0) begin m_req = 1; m_id = 5'(ms); end
      end
      m_edge = (m_edge & ~mclr) | (m_in1 & ~m_in2 & EDGE);
      m_in2 = m_in1;
      m_in1 = irq & MASK;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    chk("req", irq_req_o, m_req);
    chk("id", irq_id_o, m_id);
    chk("pending", pending_o, (m_in1 & ~EDGE) | m_edge);
    chk("busy", busy_o, m_req || m_quiet > 0);
`ifdef CV32E41S_IRQ_SEQ_STATS_EN
    chk("ack_cnt", ack_cnt_o, m_acks);
    chk("wdraw_cnt", wdraw_cnt_o, m_wd);
`endif
  endtask
  task automatic wait_req(input int max, output int cnt);
    cnt = 0;
    while (!irq_req_o && cnt < max) begin step(); cnt++; end
    chk("wait_req", irq_req_o, 1);
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step();
  endtask
  initial begin
    rst = 1; irq = 0; mie = 0; gen = 0; ack = 0;
    idle(2);
    rst = 0;
    chk("rst_req", irq_req_o, 0);
    chk("rst_id", irq_id_o, 0);
    chk("rst_pending", pending_o, 0);
    chk("rst_busy", busy_o, 0);
    irq = 32'h5; mie = '1; gen = 1;
    idle(3);
    chk("unimpl_pending", pending_o, 0);
    chk("unimpl_req", irq_req_o, 0);
    irq = 32'h800; mie = 32'h800;
    step();
    chk("lvl_lat1", irq_req_o, 0);
    step();
    chk("lvl_lat2", irq_req_o, 1);
    chk("lvl_id", irq_id_o, 11);
    irq = 0;
    step();
    chk("wd_hold", irq_req_o, 1);
    step();
    chk("wd_req", irq_req_o, 0);
    chk("wd_busy", busy_o, 0);
    mie = 32'h0001_0088; irq = 32'h0001_0088;
    wait_req(5, n);
    chk("prio_lat", n, 2);
    chk("prio_id16", irq_id_o, 16);
    ack = 1; irq = 32'h88;
    step();
    ack = 0;
    chk("gap_req", irq_req_o, 0);
    chk("gap_busy", busy_o, 1);
    wait_req(6, n);
    chk("gap_len", n, 3);
    chk("prio_id3", irq_id_o, 3);
    ack = 1; irq = 32'h80;
    step();
    ack = 0;
    wait_req(6, n);
    chk("gap_len2", n, 3);
    chk("prio_id7", irq_id_o, 7);
    ack = 1; irq = 0;
    step();
    ack = 0;
    idle(3);
    mie = 32'h0010_0000; irq = 32'h0010_0000;
    step();
    irq = 0;
    step();
    chk("edge_pend", pending_o, 32'h0010_0000);
    wait_req(4, n);
    chk("edge_lat", n, 1);
    chk("edge_id", irq_id_o, 20);
    idle(2);
    chk("edge_hold", pending_o, 32'h0010_0000);
    irq = 32'h0010_0000;
    step();
    ack = 1; irq = 0;
    step();
    ack = 0;
    chk("edge_setwins", pending_o, 32'h0010_0000);
    chk("edge_ack_req", irq_req_o, 0);
    wait_req(6, n);
    chk("edge_again_len", n, 3);
    chk("edge_again_id", irq_id_o, 20);
    ack = 1;
    step();
    ack = 0;
    chk("edge_clr", pending_o, 0);
    idle(3);
    mie = 32'h8000_0020; irq = 32'h20;
    wait_req(5, n);
    chk("id5", irq_id_o, 5);
    irq = 32'h8000_0020;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("nopreempt", irq_id_o, 5);
    end
    ack = 1; irq = 32'h8000_0000;
    step();
    ack = 0;
    wait_req(6, n);
    chk("id31", irq_id_o, 31);
    ack = 1; irq = 0;
    step();
    ack = 0;
    idle(3);
    mie = 32'h800; irq = 32'h800;
    wait_req(5, n);
    ack = 1; gen = 0; irq = 0;
    step();
    ack = 0; gen = 1;
    chk("ackwins_req", irq_req_o, 0);
    chk("ackwins_busy", busy_o, 1);
    idle(3);
    irq = 32'h0002_0000;
    step();
    irq = 0;
    step();
    chk("e17_pend", pending_o, 32'h0002_0000);
    irq = 32'h800;
    wait_req(5, n);
    chk("e17_id", irq_id_o, 11);
    ack = 1; irq = 0;
    step();
    ack = 0;
    chk("e17_gap", busy_o, 1);
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_req", irq_req_o, 0);
    chk("mid_rst_pending", pending_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_id", irq_id_o, 0);
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
